// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: ALU op encodings and the multiply/divide op set
// consumed by ex_muldiv.
package lc3b_types;

  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_and  = 4'd1,
    alu_not  = 4'd2,
    alu_pass = 4'd3,
    alu_sll  = 4'd4,
    alu_srl  = 4'd5,
    alu_sra  = 4'd6,
    alu_mult = 4'd7,
    alu_div  = 4'd8
  } lc3b_aluop;

  typedef enum logic [1:0] {
    md_mulu = 2'd0,
    md_muls = 2'd1,
    md_divu = 2'd2,
    md_divs = 2'd3
  } lc3b_mdop;

  function automatic logic mdop_is_div(input lc3b_mdop op);
    return op[1];
  endfunction

  function automatic logic mdop_is_signed(input lc3b_mdop op);
    return op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring
// divide on the {hi, lo} working register. Divide path needs EX_MULDIV_DIV_EN.
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;

  // Multiply: conditionally add the multiplicand to the high half, then shift right.
  assign sum_s      = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                      (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {sum_s, acc[WIDTH-1:1]};

`ifdef EX_MULDIV_DIV_EN
  logic [WIDTH:0]       rem_sh_s;
  logic [WIDTH:0]       diff_s;
  logic [2*WIDTH-1:0]   div_next_s;

  // Divide: shift the next dividend bit into the remainder and keep the
  // subtraction only when it does not go negative (bit WIDTH is the borrow).
  assign rem_sh_s   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff_s     = rem_sh_s - {1'b0, operand};
  assign div_next_s = diff_s[WIDTH] ? {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {diff_s[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
  assign acc_next   = is_div ? div_next_s : mul_next_s;
`else
  logic unused_is_div_s;
  assign unused_is_div_s = is_div;
  assign acc_next        = mul_next_s;
`endif

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit with start/done handshake.
// Divide, divide-by-zero and overflow handling exist only with EX_MULDIV_DIV_EN.
module ex_muldiv
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  lc3b_mdop         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [2*WIDTH-1:0]   acc_r, acc_s, step_acc_s, prod_s;
  logic [WIDTH-1:0]     opnd_r, opnd_s;
  logic                 div_r, div_s, neg_res_r, neg_res_s, neg_rem_r, neg_rem_s;
  logic                 busy_r, busy_s, done_r, done_s, dbz_r, dbz_s;
  logic [WIDTH-1:0]     lo_r, lo_s, hi_r, hi_s, fin_lo_s, fin_hi_s;
  logic                 a_neg_s, b_neg_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s, quot_s, rem_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (div_r),
    .acc      (acc_r),
    .operand  (opnd_r),
    .acc_next (step_acc_s)
  );

  // Signed ops run on magnitudes; the recorded signs fix up the final iteration.
  assign a_neg_s  = mdop_is_signed(op) & a[WIDTH-1];
  assign b_neg_s  = mdop_is_signed(op) & b[WIDTH-1];
  assign a_mag_s  = a_neg_s ? -a : a;
  assign b_mag_s  = b_neg_s ? -b : b;
  assign prod_s   = neg_res_r ? -step_acc_s : step_acc_s;
  assign quot_s   = neg_res_r ? -step_acc_s[WIDTH-1:0] : step_acc_s[WIDTH-1:0];
  assign rem_s    = neg_rem_r ? -step_acc_s[2*WIDTH-1:WIDTH] : step_acc_s[2*WIDTH-1:WIDTH];
  assign fin_lo_s = div_r ? quot_s : prod_s[WIDTH-1:0];
  assign fin_hi_s = div_r ? rem_s  : prod_s[2*WIDTH-1:WIDTH];

  // Next-state and next-output logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    acc_s     = acc_r;
    opnd_s    = opnd_r;
    div_s     = div_r;
    neg_res_s = neg_res_r;
    neg_rem_s = neg_rem_r;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    lo_s      = lo_r;
    hi_s      = hi_r;
    dbz_s     = dbz_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if ((state_r == S_DONE) && flush) begin
          state_s = S_IDLE;
        end else if (start) begin
          div_s     = mdop_is_div(op);
          opnd_s    = b_mag_s;
          acc_s     = {{WIDTH{1'b0}}, a_mag_s};
          cnt_s     = {CW{1'b0}};
          neg_res_s = a_neg_s ^ b_neg_s;
          neg_rem_s = a_neg_s;
          if (mdop_is_div(op)) begin
`ifdef EX_MULDIV_DIV_EN
            if (b == {WIDTH{1'b0}}) begin
              state_s = S_DONE;
              done_s  = 1'b1;
              lo_s    = {WIDTH{1'b1}};
              hi_s    = a;
              dbz_s   = 1'b1;
            end else begin
              state_s = S_CALC;
              busy_s  = 1'b1;
            end
`else
            state_s = S_DONE;
            done_s  = 1'b1;
            lo_s    = {WIDTH{1'b0}};
            hi_s    = {WIDTH{1'b0}};
            dbz_s   = 1'b0;
`endif
          end else begin
            state_s = S_CALC;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_s = S_IDLE;
        end else begin
          acc_s = step_acc_s;
          cnt_s = cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_s = S_DONE;
            done_s  = 1'b1;
            lo_s    = fin_lo_s;
            hi_s    = fin_hi_s;
            dbz_s   = 1'b0;
          end else begin
            busy_s  = 1'b1;
          end
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      div_r     <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      lo_r      <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      dbz_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      acc_r     <= acc_s;
      opnd_r    <= opnd_s;
      div_r     <= div_s;
      neg_res_r <= neg_res_s;
      neg_rem_r <= neg_rem_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      lo_r      <= lo_s;
      hi_r      <= hi_s;
      dbz_r     <= dbz_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign result_lo   = lo_r;
  assign result_hi   = hi_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (WIDTH=16); divide vectors follow
// EX_MULDIV_DIV_EN.
module tb_ex_muldiv;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  lc3b_mdop    op = md_mulu;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [15:0] result_lo, result_hi;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one op in the current cycle, wait for done, check latency/busy/results.
  task automatic run(input string tag, input lc3b_mdop o, input logic [15:0] ai,
                     input logic [15:0] bi, input int exp_lat, input logic [15:0] exp_lo,
                     input logic [15:0] exp_hi, input logic exp_dbz);
    int lat;
    int busy_cnt;
    op = o; a = ai; b = bi; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
    chk({tag, " lo"}, result_lo, exp_lo);
    chk({tag, " hi"}, result_hi, exp_hi);
    chk({tag, " div_by_zero"}, div_by_zero, exp_dbz);
  endtask

  initial begin
    int dones;
    logic [15:0] lo_seen;

    tick(); tick();
    reset = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset lo", result_lo, 16'h0000);
    chk("reset hi", result_hi, 16'h0000);
    chk("reset dbz", div_by_zero, 1'b0);

    run("mulu ff*101", md_mulu, 16'h00FF, 16'h0101, 17, 16'hFFFF, 16'h0000, 1'b0);
    tick();
    chk("done single pulse", done, 1'b0);

    run("muls -2*3", md_muls, 16'hFFFE, 16'h0003, 17, 16'hFFFA, 16'hFFFF, 1'b0);
    run("b2b mulu 2*3", md_mulu, 16'h0002, 16'h0003, 17, 16'h0006, 16'h0000, 1'b0);
    tick();
    chk("after b2b done", done, 1'b0);
    chk("after b2b busy", busy, 1'b0);

    // Flush during the fifth CALC cycle.
    op = md_mulu; a = 16'h0003; b = 16'h0005; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre-flush busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", busy, 1'b0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    chk("flush no done", dones, 0);
    chk("flush lo kept", result_lo, 16'h0006);
    chk("flush hi kept", result_hi, 16'h0000);

    // Start toggled while in CALC must not queue a second op.
    op = md_mulu; a = 16'h0007; b = 16'h0009; start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      start = ~start;
      a = 16'h0001; b = 16'h0001;
      tick();
    end
    start = 1'b0;
    dones = 0;
    lo_seen = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        dones++;
        lo_seen = result_lo;
      end
      tick();
    end
    chk("toggle done count", dones, 1);
    chk("toggle lo", lo_seen, 16'h003F);

`ifdef EX_MULDIV_DIV_EN
    run("divs -7/2", md_divs, 16'hFFF9, 16'h0002, 17, 16'hFFFD, 16'hFFFF, 1'b0);
    tick();
    run("divu 100/7", md_divu, 16'h0064, 16'h0007, 17, 16'h000E, 16'h0002, 1'b0);
    tick();
    run("divs ovf", md_divs, 16'h8000, 16'hFFFF, 17, 16'h8000, 16'h0000, 1'b0);
    tick();
    run("divu by 0", md_divu, 16'h1234, 16'h0000, 1, 16'hFFFF, 16'h1234, 1'b1);
    tick();
    chk("dbz held", div_by_zero, 1'b1);
`else
    run("divu no-div", md_divu, 16'h0064, 16'h0007, 1, 16'h0000, 16'h0000, 1'b0);
    tick();
    run("divs no-div", md_divs, 16'hFFF9, 16'h0002, 1, 16'h0000, 16'h0000, 1'b0);
    tick();
`endif

    // Reset in the middle of CALC clears every output.
    run("mulu ffff*ffff", md_mulu, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 1'b0);
    op = md_muls; a = 16'h0005; b = 16'h0005; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("midreset busy", busy, 1'b0);
    chk("midreset done", done, 1'b0);
    chk("midreset lo", result_lo, 16'h0000);
    chk("midreset hi", result_hi, 16'h0000);
    chk("midreset dbz", div_by_zero, 1'b0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    chk("midreset no done", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit for the LC-3b execute stage, replacing the single-cycle combinational multiplier path. It accepts one operation at a time over a start/done handshake, performs shift-add multiplication or restoring division over WIDTH cycles, and returns a double-width product or a quotient/remainder pair. While an operation is in flight, the pipeline holds EX and upstream stages using `start & ~done`; that stall term is generated outside this block.

## Interface
- WIDTH, 16, operand width in bits; legal range 4–32.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE or DONE.
- op  in  2  lc3b_mdop: md_mulu, md_muls, md_divu, md_divs.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- flush  in  1  abort the in-flight operation (branch mispredict or trap).
- busy  out  1  high while in CALC.
- done  out  1  single-cycle pulse; results are valid in the same cycle.
- result_lo  out  WIDTH  product low half, or quotient.
- result_hi  out  WIDTH  product high half, or remainder.
- div_by_zero  out  1  set with done when a divide had b == 0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 registers a, b and op, clears the iteration counter, and moves to CALC.
  - Exception: a divide with b == 0 goes directly to DONE.
- Signed ops (md_muls, md_divs):
  - Operands are converted to magnitudes at accept time and the operand signs are recorded.
  - Sign correction is applied on the final CALC edge, before results are registered.
- Multiply: one shift-add step per CALC cycle, giving a 2·WIDTH-bit product split into hi and lo.
- Divide: one restoring step per CALC cycle.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Division by zero: result_lo = all ones, result_hi = a, div_by_zero = 1.
- Signed overflow (most-negative ÷ −1): result_lo = most-negative value, result_hi = 0, div_by_zero = 0.
- CALC: after WIDTH cycles, move to DONE.
- DONE: done=1 for exactly one cycle.
  - If start=1 in this cycle, accept the new operation (back-to-back) and go to CALC.
  - Otherwise go to IDLE.
- start while in CALC is ignored; the requester keeps start asserted.
- Results and div_by_zero hold their values until the next operation's DONE.
- flush while in CALC or DONE:
  - Next state is IDLE; no done pulse is produced.
  - Results keep their prior values.
  - flush takes priority over start in the same cycle.
- Reset: state = IDLE; busy, done, result_lo, result_hi and div_by_zero are all 0. Reset takes priority over everything, including mid-CALC.

## Timing
- The accept cycle N is the cycle in which start=1 is sampled in IDLE or DONE.
- Normal latency: busy is high in cycles N+1 … N+WIDTH, and done is high in cycle N+WIDTH+1.
- Divide-by-zero latency: done is high in cycle N+1, and busy never rises.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts.
- All outputs are registered; none has a combinational path from an input.

## Configuration
- Macro: EX_MULDIV_DIV_EN.
- Defined: divide datapath, divide-by-zero handling and overflow handling are all present.
- Undefined:
  - The divide logic is not compiled in.
  - md_divu and md_divs complete with done in cycle N+1, result_lo = result_hi = 0 and div_by_zero = 0.
  - Multiply behaviour is unchanged.

## Structure
- lc3b_types gains:
  - the lc3b_mdop enum;
  - the alu_mult and alu_div aluop encodings used by the control word to drive start.
- The state enum is local to this module.
- One sub-module, muldiv_step:
  - combinational single-iteration shift/add-or-subtract of the partial remainder or product register;
  - parametrised by WIDTH;
  - selected by a multiply/divide flag.

## Test plan
- md_mulu, a=0x00FF, b=0x0101 at cycle N -> busy in N+1..N+16; done in N+17 with hi=0x0000, lo=0xFFFF.
- md_muls, a=0xFFFE, b=0x0003 -> hi=0xFFFF, lo=0xFFFA; then in the DONE cycle start md_mulu 0x0002×0x0003 -> done 17 cycles later with lo=0x0006.
- md_divs, a=0xFFF9, b=0x0002 -> lo=0xFFFD, hi=0xFFFF. Also md_divu, a=0x0064, b=0x0007 -> lo=0x000E, hi=0x0002.
- md_divu, a=0x1234, b=0 -> done in N+1, lo=0xFFFF, hi=0x1234, div_by_zero=1. Also md_divs, a=0x8000, b=0xFFFF -> lo=0x8000, hi=0x0000, done in N+17.
- flush in the 5th CALC cycle -> IDLE next cycle, no done, results unchanged. Separately, reset mid-CALC -> all outputs 0 next cycle.
- start toggled during CALC -> ignored, and only one done occurs. With EX_MULDIV_DIV_EN undefined, md_divu -> done in N+1 with zero results.
